cprv_lsu: RTL and testbench
===========================

Name: cprv_lsu

Overview:
Memory-access stage directly downstream of the execute-stage ALU. It consumes the ALU result together with the instruction's opcode, funct3, rd and rs2 data.
- LOAD/STORE: the ALU result is the effective address. The block runs one data-bus transaction, aligning and extending load data and generating byte strobes for stores.
- All other opcodes: the ALU result passes straight to writeback.
- Sits between execute and the register-file writeback port.

Parameters:
DATA_WIDTH, 64, datapath and address width
REGADDR_WIDTH, 5, register index width
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width

Ports:
clk  input  1  core clock
rst_n  input  1  synchronous active-low reset
ex_valid  input  1  execute stage presents an instruction
ex_ready  output  1  LSU accepts this cycle
opcode  input  7  instruction opcode
funct3  input  3  instruction funct3
rd  input  REGADDR_WIDTH  destination register
alu_out  input  DATA_WIDTH  ALU result / effective address
store_data  input  DATA_WIDTH  rs2 value
mem_req  output  1  bus request
mem_we  output  1  1 = write
mem_addr  output  DATA_WIDTH  doubleword-aligned address
mem_wstrb  output  STRB_WIDTH  byte enables
mem_wdata  output  DATA_WIDTH  lane-shifted write data
mem_ack  input  1  bus completes the transaction
mem_rdata  input  DATA_WIDTH  read data, valid with mem_ack
wb_valid  output  1  one-cycle retire pulse
wb_we  output  1  register write enable
wb_rd  output  REGADDR_WIDTH  writeback register
wb_data  output  DATA_WIDTH  writeback value
exc_valid  output  1  one-cycle exception pulse
exc_cause  output  2  0 load misaligned, 1 store misaligned, 2 illegal funct3
exc_addr  output  DATA_WIDTH  faulting address

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is synchronous, active-low.
- Reset values: state IDLE; all outputs 0 except ex_ready.
  - ex_ready is 0 while rst_n is low and 1 in the first cycle after release.
- FSM has two states, IDLE and BUSY. ex_ready = (state == IDLE). Acceptance occurs on ex_valid && ex_ready.
- IDLE, accepting a non-memory opcode:
  - Next cycle: wb_valid=1, wb_data=alu_out, wb_rd=rd, wb_we=(rd!=0). Latency 1.
- IDLE, accepting LOAD/STORE, legal and aligned:
  - Register address, size, sign flag, rd and lane data; go to BUSY.
  - mem_req goes high the following cycle.
- Legality:
  - LOAD funct3 111 is illegal; STORE funct3 1xx is illegal.
  - Alignment: halfword requires addr[0]=0, word requires addr[1:0]=0, doubleword requires addr[2:0]=0.
  - Illegal or misaligned access: next cycle exc_valid=1 with the matching cause and exc_addr=alu_out. No bus request, wb_valid=0, state stays IDLE.
  - Illegal funct3 takes priority over misalignment.
- Bus fields, with a = addr[2:0]:
  - mem_addr = {addr[63:3],3'b000}.
  - mem_wstrb = size mask (0x01/0x03/0x0F/0xFF) << a.
  - mem_wdata = store_data << (8*a).
  - Loads drive mem_we=0 and mem_wstrb=0.
- BUSY:
  - mem_req=1, and all mem_* outputs are held stable until mem_ack is sampled high.
  - mem_ack may arrive in the first cycle mem_req is high. mem_ack while mem_req=0 is ignored.
  - On ack, next cycle: wb_valid=1 and state returns to IDLE.
    - Load: wb_data = extract (mem_rdata >> 8*a) at the access size, sign-extended for LB/LH/LW and zero-extended for LBU/LHU/LWU/LD. wb_we=(rd!=0).
    - Store: wb_we=0, wb_data=0.
  - mem_req drops in the same edge that raises wb_valid.
- Throughput:
  - Memory op: acceptance at cycle 0, mem_req at cycle 1, ack at cycle N≥1, wb_valid at N+1. The next acceptance is possible at N+1.
  - Non-memory ops: back-to-back at 1 per cycle.
- wb_valid and exc_valid are never both high.
- Reset mid-BUSY:
  - Next edge: mem_req=0, state IDLE, no wb/exc pulse. The bus must tolerate an abandoned request.
  - A late mem_ack is ignored.

Decomposition:
- cprv_pkg: DATA_WIDTH and REGADDR_WIDTH defaults, LOAD/STORE opcode constants, load/store funct3 encodings, exc_cause enum, access-size enum.
- Sub-module cprv_load_align: combinational rdata shift plus sign/zero extension (inputs rdata, offset, size, unsigned; output data).

Test Plan:
- ADD path, alu_out=0x1234, rd=5 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234, no mem_req.
- LB, alu_out=0x1003, mem_rdata=0x1122334485667788, ack on first req cycle -> mem_addr=0x1000, wb_data=0xFFFFFFFFFFFFFF85; same access as LBU -> 0x85.
- SH, alu_out=0x2006, store_data=0xABCD -> mem_we=1, mem_wstrb=0xC0, mem_wdata[63:48]=0xABCD, then wb_valid=1 with wb_we=0.
- LW, alu_out=0x3002 -> exc_valid=1, exc_cause=0, exc_addr=0x3002, mem_req never high, ex_ready stays 1; LOAD funct3=111 -> exc_cause=2.
- LD, alu_out=0x4000, ack delayed 5 cycles -> mem_req/addr stable for 5 cycles, ex_ready=0 throughout, exactly one wb_valid one cycle after ack.
- rst_n low during BUSY -> next edge mem_req=0, state IDLE, a subsequent mem_ack produces no wb_valid.

Source files
------------

// File: rtl/cprv_pkg.sv
// Shared types and constants for the cprv load/store unit: opcodes, funct3
// encodings, access sizes, exception causes and the alignment helper.
package cprv_pkg;

  localparam int DATA_WIDTH_DEF    = 64;
  localparam int REGADDR_WIDTH_DEF = 5;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    EXC_LOAD_MISALIGN  = 2'd0,
    EXC_STORE_MISALIGN = 2'd1,
    EXC_ILLEGAL_F3     = 2'd2
  } exc_cause_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // An access is misaligned when any address bit below its natural size is set.
  function automatic logic misaligned(size_e size, logic [2:0] a);
    logic r;
    case (size)
      SIZE_B:  r = 1'b0;
      SIZE_H:  r = a[0];
      SIZE_W:  r = |a[1:0];
      SIZE_D:  r = |a[2:0];
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cprv_mem_if.sv
// Data-bus bundle between the LSU (master) and memory (slave).
interface cprv_mem_if #(
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cprv_load_align.sv
// Moves the addressed lane of a read doubleword down to bit 0 and
// sign- or zero-extends it to the full register width.
module cprv_load_align
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [OFF_W-1:0]      offset_i,
  input  size_e                 size_i,
  input  logic                  unsigned_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] shifted_s;

  assign shifted_s = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = shifted_s;
    case (size_i)
      SIZE_B:  data_o = {{(DATA_WIDTH-8){~unsigned_i & shifted_s[7]}},   shifted_s[7:0]};
      SIZE_H:  data_o = {{(DATA_WIDTH-16){~unsigned_i & shifted_s[15]}}, shifted_s[15:0]};
      SIZE_W:  data_o = {{(DATA_WIDTH-32){~unsigned_i & shifted_s[31]}}, shifted_s[31:0]};
      SIZE_D:  data_o = shifted_s;
      default: data_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/cprv_lsu.sv
// Memory-access stage: forwards ALU results to writeback, or runs one
// aligned data-bus transaction for loads/stores, raising exceptions otherwise.
module cprv_lsu
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int REGADDR_WIDTH = REGADDR_WIDTH_DEF,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [REGADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0]    alu_out,
  input  logic [DATA_WIDTH-1:0]    store_data,
  cprv_mem_if.master               mem,
  output logic                     wb_valid,
  output logic                     wb_we,
  output logic [REGADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     exc_valid,
  output logic [1:0]               exc_cause,
  output logic [DATA_WIDTH-1:0]    exc_addr
);

  localparam int OFF_W = $clog2(STRB_WIDTH);

  state_e                   state_q, state_d;
  logic                     mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]    mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [STRB_WIDTH-1:0]    mem_wstrb_q, mem_wstrb_d;
  logic [OFF_W-1:0]         off_q, off_d;
  size_e                    size_q, size_d;
  logic                     uns_q, uns_d, ld_q, ld_d;
  logic [REGADDR_WIDTH-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic                     wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d, exc_addr_q, exc_addr_d;
  logic                     exc_valid_q, exc_valid_d;
  exc_cause_e               exc_cause_q, exc_cause_d;

  logic                  is_load_s, is_store_s, illegal_s, misalign_s, accept_s;
  size_e                 size_s;
  logic [OFF_W-1:0]      off_s;
  logic [STRB_WIDTH-1:0] size_mask_s;
  logic [DATA_WIDTH-1:0] load_data_s;

  // ex_ready is gated by rst_n so it reads 0 throughout reset, not only after the first edge.
  assign ex_ready   = rst_n && (state_q == ST_IDLE);
  assign accept_s   = ex_valid && ex_ready;
  assign is_load_s  = (opcode == OPC_LOAD);
  assign is_store_s = (opcode == OPC_STORE);
  assign size_s     = size_e'(funct3[1:0]);
  assign off_s      = alu_out[OFF_W-1:0];
  assign illegal_s  = (is_load_s && (funct3 == 3'b111)) || (is_store_s && funct3[2]);
  assign misalign_s = misaligned(size_s, alu_out[2:0]);

  always_comb begin
    size_mask_s = '0;
    case (size_s)
      SIZE_B:  size_mask_s = STRB_WIDTH'(8'h01);
      SIZE_H:  size_mask_s = STRB_WIDTH'(8'h03);
      SIZE_W:  size_mask_s = STRB_WIDTH'(8'h0F);
      SIZE_D:  size_mask_s = STRB_WIDTH'(8'hFF);
      default: size_mask_s = '0;
    endcase
  end

  cprv_load_align #(.DATA_WIDTH(DATA_WIDTH), .OFF_W(OFF_W)) u_align (
    .rdata_i    (mem.mem_rdata),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data_s)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    ld_d        = ld_q;
    rd_d        = rd_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_addr_d  = exc_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (!accept_s) begin
          state_d = ST_IDLE;
        end else if (!is_load_s && !is_store_s) begin
          wb_valid_d = 1'b1;
          wb_we_d    = (rd != '0);
          wb_rd_d    = rd;
          wb_data_d  = alu_out;
        end else if (illegal_s || misalign_s) begin
          // Illegal funct3 outranks misalignment when both apply.
          exc_valid_d = 1'b1;
          exc_addr_d  = alu_out;
          if (illegal_s) begin
            exc_cause_d = EXC_ILLEGAL_F3;
          end else begin
            exc_cause_d = is_load_s ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
          end
        end else begin
          state_d     = ST_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = is_store_s;
          mem_addr_d  = {alu_out[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          mem_wstrb_d = is_store_s ? (size_mask_s << off_s) : '0;
          mem_wdata_d = is_store_s ? (store_data << {off_s, 3'b000}) : '0;
          off_d       = off_s;
          size_d      = size_s;
          uns_d       = funct3[2];
          ld_d        = is_load_s;
          rd_d        = rd;
        end
      end
      ST_BUSY: begin
        if (mem.mem_ack) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = ld_q && (rd_q != '0);
          wb_data_d  = ld_q ? load_data_s : '0;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      off_q       <= '0;
      size_q      <= SIZE_B;
      uns_q       <= 1'b0;
      ld_q        <= 1'b0;
      rd_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= EXC_LOAD_MISALIGN;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wstrb = mem_wstrb_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_we         = wb_we_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign exc_valid     = exc_valid_q;
  assign exc_cause     = exc_cause_q;
  assign exc_addr      = exc_addr_q;

endmodule

// File: tb/tb_cprv_lsu.sv
// Directed bench for cprv_lsu: a byte-arithmetic model sets per-cycle
// expectations and a negedge process compares every output against them.
module tb_cprv_lsu;
  localparam int DW = 64;
  localparam int RW = 5;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ex_valid, ex_ready;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [RW-1:0] rd;
  logic [DW-1:0] alu_out, store_data;
  logic          wb_valid, wb_we, exc_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data, exc_addr;
  logic [1:0]    exc_cause;

  cprv_mem_if #(.DATA_WIDTH(DW)) mem_bus ();

  cprv_lsu #(.DATA_WIDTH(DW), .REGADDR_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .opcode(opcode), .funct3(funct3), .rd(rd), .alu_out(alu_out),
    .store_data(store_data), .mem(mem_bus.master),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  logic          exp_ready, exp_req, exp_we, exp_wbv, exp_wbwe, exp_excv;
  logic [DW-1:0] exp_addr, exp_wdata, exp_wbdata, exp_excaddr;
  logic [7:0]    exp_strb;
  logic [RW-1:0] exp_wbrd;
  logic [1:0]    exp_cause;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_bytes(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit m_legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == OP_LOAD) return f3 != 3'd7;
    return f3 < 3'd4;
  endfunction

  function automatic bit m_aligned(input logic [2:0] f3, input logic [63:0] addr);
    return (addr % 64'(m_bytes(f3))) == 64'd0;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rdat, input logic [63:0] addr,
                                         input logic [2:0] f3);
    int nb = m_bytes(f3);
    int off = int'(addr % 64'd8);
    logic [63:0] v = rdat >> (8 * off);
    logic [63:0] r = '0;
    for (int i = 0; i < 64; i++)
      r[i] = (i < 8 * nb) ? v[i] : ((f3 < 3'd4) ? v[8 * nb - 1] : 1'b0);
    return r;
  endfunction

  function automatic logic [7:0] m_strb(input logic [63:0] addr, input logic [2:0] f3);
    int mask = (1 << m_bytes(f3)) - 1;
    int sh = mask << int'(addr % 64'd8);
    return sh[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] sd, input logic [63:0] addr);
    return sd << (8 * int'(addr % 64'd8));
  endfunction

  // Per-cycle comparison of every DUT output against the model expectation.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ex_ready", 64'(ex_ready), 64'(exp_ready));
      chk("mem_req", 64'(mem_bus.mem_req), 64'(exp_req));
      chk("wb_valid", 64'(wb_valid), 64'(exp_wbv));
      chk("exc_valid", 64'(exc_valid), 64'(exp_excv));
      if (exp_req) begin
        chk("mem_we", 64'(mem_bus.mem_we), 64'(exp_we));
        chk("mem_addr", mem_bus.mem_addr, exp_addr);
        chk("mem_wstrb", 64'(mem_bus.mem_wstrb), 64'(exp_strb));
        if (exp_we) chk("mem_wdata", mem_bus.mem_wdata, exp_wdata);
      end
      if (exp_wbv) begin
        chk("wb_we", 64'(wb_we), 64'(exp_wbwe));
        chk("wb_rd", 64'(wb_rd), 64'(exp_wbrd));
        chk("wb_data", wb_data, exp_wbdata);
      end
      if (exp_excv) begin
        chk("exc_cause", 64'(exc_cause), 64'(exp_cause));
        chk("exc_addr", exc_addr, exp_excaddr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_ready = 1'b1; exp_req = 1'b0; exp_wbv = 1'b0; exp_excv = 1'b0;
  endtask

  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [RW-1:0] r,
                       input logic [63:0] addr, input logic [63:0] sd,
                       input logic [63:0] rdat, input int d);
    bit is_mem = (op == OP_LOAD) || (op == OP_STORE);
    opcode = op; funct3 = f3; rd = r; alu_out = addr; store_data = sd; ex_valid = 1'b1;
    set_idle();
    tick();
    ex_valid = 1'b0;
    if (!is_mem) begin
      exp_wbv = 1'b1; exp_wbwe = (r != 0); exp_wbrd = r; exp_wbdata = addr;
      tick();
    end else if (!m_legal(op, f3) || !m_aligned(f3, addr)) begin
      exp_excv = 1'b1; exp_excaddr = addr;
      exp_cause = !m_legal(op, f3) ? 2'd2 : ((op == OP_LOAD) ? 2'd0 : 2'd1);
      tick();
    end else begin
      exp_ready = 1'b0; exp_req = 1'b1; exp_we = (op == OP_STORE);
      exp_addr = addr - (addr % 64'd8);
      exp_strb = (op == OP_STORE) ? m_strb(addr, f3) : 8'h00;
      exp_wdata = m_wdata(sd, addr);
      for (int k = 1; k <= d; k++) begin
        mem_bus.mem_ack = (k == d);
        mem_bus.mem_rdata = (k == d) ? rdat : 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
      end
      mem_bus.mem_ack = 1'b0;
      exp_req = 1'b0; exp_ready = 1'b1; exp_wbv = 1'b1;
      exp_wbwe = (op == OP_LOAD) && (r != 0); exp_wbrd = r;
      exp_wbdata = (op == OP_LOAD) ? m_load(rdat, addr, f3) : 64'd0;
      tick();
    end
    set_idle();
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; opcode = 7'd0; funct3 = 3'd0; rd = '0;
    alu_out = 64'd0; store_data = 64'd0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 64'd0;

    // Model pins against hand-computed values.
    chk("pin_lb", m_load(64'h1122334485667788, 64'h1003, 3'b000), 64'hFFFF_FFFF_FFFF_FF85);
    chk("pin_lbu", m_load(64'h1122334485667788, 64'h1003, 3'b100), 64'h85);
    chk("pin_sh_strb", 64'(m_strb(64'h2006, 3'b001)), 64'hC0);
    chk("pin_sh_wdata", m_wdata(64'hABCD, 64'h2006), 64'hABCD_0000_0000_0000);
    chk("pin_lw_align", 64'(m_aligned(3'b010, 64'h3002)), 64'd0);
    chk("pin_ld_legal", 64'(m_legal(OP_LOAD, 3'b111)), 64'd0);

    // Reset state.
    tick();
    set_idle(); exp_ready = 1'b0; chk_on = 1'b1;
    tick();
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_mem_addr", mem_bus.mem_addr, 64'd0);
    chk("rst_mem_wstrb", 64'(mem_bus.mem_wstrb), 64'd0);
    chk("rst_exc_addr", exc_addr, 64'd0);
    rst_n = 1'b1; set_idle();
    tick();

    do_op(OP_ALU,   3'b000, 5'd5, 64'h1234, 64'd0, 64'd0, 1);
    do_op(OP_ALU,   3'b000, 5'd0, 64'h5555, 64'd0, 64'd0, 1);
    do_op(OP_LOAD,  3'b000, 5'd7, 64'h1003, 64'd0, 64'h1122334485667788, 1);
    do_op(OP_LOAD,  3'b100, 5'd7, 64'h1003, 64'd0, 64'h1122334485667788, 1);
    do_op(OP_STORE, 3'b001, 5'd0, 64'h2006, 64'hABCD, 64'd0, 1);
    do_op(OP_LOAD,  3'b010, 5'd8, 64'h3002, 64'd0, 64'd0, 1);
    do_op(OP_LOAD,  3'b111, 5'd8, 64'h3000, 64'd0, 64'd0, 1);
    do_op(OP_STORE, 3'b101, 5'd0, 64'h5001, 64'd0, 64'd0, 1);
    do_op(OP_STORE, 3'b011, 5'd0, 64'h5004, 64'd0, 64'd0, 1);
    do_op(OP_LOAD,  3'b011, 5'd9, 64'h4000, 64'd0, 64'h8877665544332211, 5);
    do_op(OP_LOAD,  3'b001, 5'd10, 64'h6002, 64'd0, 64'h0000_0000_9ABC_0000, 2);
    do_op(OP_LOAD,  3'b101, 5'd10, 64'h6002, 64'd0, 64'h0000_0000_9ABC_0000, 1);
    do_op(OP_LOAD,  3'b110, 5'd11, 64'h6004, 64'd0, 64'hF0E0D0C0_00000000, 1);
    do_op(OP_LOAD,  3'b010, 5'd11, 64'h6004, 64'd0, 64'hF0E0D0C0_00000000, 3);
    do_op(OP_LOAD,  3'b011, 5'd0, 64'h6008, 64'd0, 64'h0123456789ABCDEF, 1);
    do_op(OP_STORE, 3'b000, 5'd0, 64'h7007, 64'h5A, 64'd0, 1);
    do_op(OP_STORE, 3'b010, 5'd0, 64'h7004, 64'hCAFEBABE, 64'd0, 2);
    do_op(OP_STORE, 3'b011, 5'd0, 64'h7000, 64'h0102030405060708, 64'd0, 1);

    // Back-to-back non-memory ops.
    opcode = OP_ALUI; funct3 = 3'd0; rd = 5'd1; alu_out = 64'h11; ex_valid = 1'b1;
    set_idle();
    tick();
    exp_wbv = 1'b1; exp_wbwe = 1'b1; exp_wbrd = 5'd1; exp_wbdata = 64'h11;
    rd = 5'd2; alu_out = 64'h22;
    tick();
    exp_wbrd = 5'd2; exp_wbdata = 64'h22; ex_valid = 1'b0;
    tick();
    set_idle();
    tick();

    // Reset while BUSY, then a late ack that must be ignored.
    opcode = OP_LOAD; funct3 = 3'b011; rd = 5'd3; alu_out = 64'h8000; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0; exp_ready = 1'b0; exp_req = 1'b1; exp_we = 1'b0;
    exp_addr = 64'h8000; exp_strb = 8'h00;
    tick();
    rst_n = 1'b0;
    tick();
    exp_req = 1'b0;
    rst_n = 1'b1; mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 64'h77;
    exp_ready = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    tick();
    tick();
    do_op(OP_ALU, 3'b000, 5'd4, 64'hBEEF, 64'd0, 64'd0, 1);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
